// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types for the FP32 adder arbiter: FSM state encoding.
package fp_adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fp_adder_arbiter_picker.sv
// Combinational winner selection for the adder arbiter.
// FP_ARB_ROUND_ROBIN_EN selects round-robin from rr_ptr+1; otherwise lowest index wins.
module fp_arb_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
`ifdef FP_ARB_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]  rr_ptr,
`endif
  output logic [ID_W-1:0]  winner,
  output logic             any_req
);

  always_comb begin
`ifdef FP_ARB_ROUND_ROBIN_EN
    logic [31:0] idx;
    logic        found;
`endif
    winner  = '0;
    any_req = |req;
`ifdef FP_ARB_ROUND_ROBIN_EN
    idx   = '0;
    found = 1'b0;
    // Walk the requesters in rotated order, first hit after the last owner wins.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(rr_ptr) + 32'd1 + i) % 32'(N_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        found  = 1'b1;
      end
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
`endif
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one FP32 adder among N_REQ requesters; all outputs registered.
// Optional round-robin arbitration via FP_ARB_ROUND_ROBIN_EN (default: fixed priority).
module fp_adder_arbiter
  import fp_adder_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]  rsp_valid,
  input  logic [N_REQ-1:0]  rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic              busy,
  output logic [ID_W-1:0]   gnt_id,
  output logic              add_load,
  output logic [DW-1:0]     add_num1,
  output logic [DW-1:0]     add_num2,
  input  logic [DW-1:0]     add_result,
  input  logic              add_result_ready,
  output logic              add_result_ack
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [DW-1:0]     num1_q, num1_d;
  logic [DW-1:0]     num2_q, num2_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic              add_load_q, add_load_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic [DW-1:0]     sel_a, sel_b;
`ifdef FP_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  fp_arb_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req     (req),
`ifdef FP_ARB_ROUND_ROBIN_EN
    .rr_ptr  (rr_ptr_q),
`endif
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (winner == ID_W'(j)) begin
        sel_a = req_a[j*DW +: DW];
        sel_b = req_b[j*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    add_load_d  = 1'b0;
    ack_d       = 1'b0;
`ifdef FP_ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          num1_d     = sel_a;
          num2_d     = sel_b;
          gnt_id_d   = winner;
          add_load_d = 1'b1;
          state_d    = ST_LOAD;
`ifdef FP_ARB_ROUND_ROBIN_EN
          rr_ptr_d   = winner;
`endif
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (add_result_ready) begin
          rsp_data_d  = add_result;
          ack_d       = 1'b1;
          rsp_valid_d = N_REQ'(1) << gnt_id_q;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[gnt_id_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered from next state so busy lines up with the state it reports.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      add_load_q  <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FP_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= ID_W'(N_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      add_load_q  <= add_load_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
`ifdef FP_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign busy           = busy_q;
  assign gnt_id         = gnt_id_q;
  assign add_load       = add_load_q;
  assign add_num1       = num1_q;
  assign add_num2       = num2_q;
  assign add_result_ack = ack_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter with a behavioural FP32 adder (lookup of known sums).
module tb_fp_adder_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, rsp_ready, rsp_valid;
  logic [127:0] req_a, req_b;
  logic [31:0]  rsp_data, add_num1, add_num2, add_result;
  logic         busy, add_load, add_result_ready, add_result_ack;
  logic [1:0]   gnt_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_adder_arbiter #(.N_REQ(4), .ID_W(2), .DW(32)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .gnt_id(gnt_id), .add_load(add_load), .add_num1(add_num1),
    .add_num2(add_num2), .add_result(add_result), .add_result_ready(add_result_ready),
    .add_result_ack(add_result_ack)
  );

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2 = 3
      {32'h3FC00000, 32'h40200000}: return 32'h40800000; // 1.5 + 2.5 = 4
      {32'h3F000000, 32'h3E800000}: return 32'h3F400000; // 0.5 + 0.25 = 0.75
      {32'h41200000, 32'h40C00000}: return 32'h41800000; // 10 + 6 = 16
      {32'h40400000, 32'hBF800000}: return 32'h40000000; // 3 + -1 = 2
      {32'hC0000000, 32'hC0000000}: return 32'hC0800000; // -2 + -2 = -4
      default:                      return 32'hFFC00000;
    endcase
  endfunction

  // Behavioural adder: result_ready 'lat' cycles after load, dropped after ack.
  int          lat = 2;
  int          cnt;
  logic        pend, m_ready, force_ready;
  logic [31:0] m_result, res;
  assign add_result       = m_result;
  assign add_result_ready = m_ready | force_ready;

  always @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0; m_ready <= 1'b0; m_result <= '0; cnt <= 0; res <= '0;
    end else begin
      if (add_load) begin
        pend <= 1'b1; cnt <= lat - 1; res <= fp_sum(add_num1, add_num2);
      end else if (pend) begin
        if (cnt == 0) begin m_ready <= 1'b1; m_result <= res; pend <= 1'b0; end
        else cnt <= cnt - 1;
      end
      if (m_ready && add_result_ack) m_ready <= 1'b0;
    end
  end

  int n_load = 0;
  int n_ack = 0;
  logic [1:0]  g_log[$];
  logic [31:0] d_log[$];
  always @(posedge clk) begin
    if (add_load) begin n_load++; g_log.push_back(gnt_id); end
    if (add_result_ack) n_ack++;
    if ((rsp_valid & rsp_ready) != 4'b0) d_log.push_back(rsp_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    int cyc = 0;
    while (rsp_valid == 4'b0 && cyc < 60) begin @(negedge clk); cyc++; end
    ok = (rsp_valid != 4'b0);
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_load(input int l0);
    int cyc = 0;
    while (n_load == l0 && cyc < 30) begin @(negedge clk); cyc++; end
    check("load_seen", 32'(n_load - l0), 32'd1);
  endtask

  task automatic txn(input int r, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    int l0, a0;
    bit ok;
    l0 = n_load; a0 = n_ack;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req[r] = 1'b1;
    wait_valid(tag, ok);
    if (ok) begin
      check({tag, "_valid"}, 32'(rsp_valid), 32'(1 << r));
      check({tag, "_data"}, rsp_data, exp);
      check({tag, "_gnt"}, 32'(gnt_id), 32'(r));
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready[r] = 1'b0;
      req[r] = 1'b0;
      check({tag, "_busy_clr"}, 32'(busy), 32'd0);
      check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
      check({tag, "_loads"}, 32'(n_load - l0), 32'd1);
      check({tag, "_acks"}, 32'(n_ack - a0), 32'd1);
    end else begin
      req[r] = 1'b0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    int          r;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] d0, exp_d[4];
    logic [1:0]  exp_g[5];
    int          l0, a0, cyc;
    bit          ok, stable;

    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000, 2};
    vecs[1] = '{1, 32'h3FC00000, 32'h40200000, 32'h40800000, 3};
    vecs[2] = '{2, 32'h3F000000, 32'h3E800000, 32'h3F400000, 4};
    vecs[3] = '{3, 32'h41200000, 32'h40C00000, 32'h41800000, 5};
    vecs[4] = '{2, 32'h40400000, 32'hBF800000, 32'h40000000, 2};
    vecs[5] = '{1, 32'hC0000000, 32'hC0000000, 32'hC0800000, 3};

    reset = 1'b0; req = '0; rsp_ready = '0; force_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'h7F7F0000 | 32'(i);
      req_b[i*32 +: 32] = 32'h7F7F0100 | 32'(i);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_load", 32'(add_load), 32'd0);
    check("rst_ack", 32'(add_result_ack), 32'd0);
    check("rst_num1", add_num1, 32'd0);
    check("rst_data", rsp_data, 32'd0);

    for (int i = 0; i < 6; i++) begin
      lat = vecs[i].lat;
      txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: result held while rsp_ready stays low.
    lat = 3; l0 = n_load;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000; req[0] = 1'b1;
    wait_valid("bp", ok);
    check("bp_data", rsp_data, 32'h40400000);
    d0 = rsp_data; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0001 || rsp_data !== d0 || busy !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_no_reload", 32'(n_load - l0), 32'd1);
    rsp_ready[0] = 1'b1; @(negedge clk); rsp_ready[0] = 1'b0; req[0] = 1'b0;
    check("bp_done", 32'(busy), 32'd0);
    @(negedge clk);

    // Requester 2 drops req and scribbles its operands after the grant.
    lat = 4; l0 = n_load;
    req_a[64 +: 32] = 32'h40400000; req_b[64 +: 32] = 32'hBF800000; req[2] = 1'b1;
    wait_load(l0);
    @(negedge clk);
    req[2] = 1'b0; req_a[64 +: 32] = 32'h12345678;
    wait_valid("drop", ok);
    check("drop_valid", 32'(rsp_valid), 32'h4);
    check("drop_data", rsp_data, 32'h40000000);
    check("drop_num1", add_num1, 32'h40400000);
    rsp_ready[2] = 1'b1; @(negedge clk); rsp_ready[2] = 1'b0;
    check("drop_done", 32'(busy), 32'd0);
    @(negedge clk);

    // Spurious result_ready in IDLE, then in RESP.
    d0 = rsp_data; a0 = n_ack;
    force_ready = 1'b1; repeat (3) @(negedge clk); force_ready = 1'b0;
    check("spur_idle_ack", 32'(n_ack - a0), 32'd0);
    check("spur_idle_data", rsp_data, d0);
    check("spur_idle_busy", 32'(busy), 32'd0);
    lat = 3; a0 = n_ack;
    req_a[32 +: 32] = 32'h3FC00000; req_b[32 +: 32] = 32'h40200000; req[1] = 1'b1;
    wait_valid("spur", ok);
    force_ready = 1'b1; repeat (3) @(negedge clk); force_ready = 1'b0;
    check("spur_resp_ack", 32'(n_ack - a0), 32'd1);
    check("spur_resp_data", rsp_data, 32'h40800000);
    check("spur_resp_valid", 32'(rsp_valid), 32'h2);
    rsp_ready[1] = 1'b1; @(negedge clk); rsp_ready[1] = 1'b0; req[1] = 1'b0;
    @(negedge clk);

    // Reset while waiting on the adder.
    lat = 5; l0 = n_load; a0 = n_ack;
    req_a[32 +: 32] = 32'h3F800000; req_b[32 +: 32] = 32'h40000000; req[1] = 1'b1;
    wait_load(l0);
    @(negedge clk);
    reset = 1'b0; req = '0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_gnt", 32'(gnt_id), 32'd0);
    check("mid_rst_num2", add_num2, 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    repeat (8) @(negedge clk);
    check("mid_rst_no_ack", 32'(n_ack - a0), 32'd0);
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    lat = 2;
    txn(3, 32'h41200000, 32'h40C00000, 32'h41800000, "post_rst");

    // Contention: all four hold req, all accept immediately.
    req_a = {32'h41200000, 32'h3F000000, 32'h3FC00000, 32'h3F800000};
    req_b = {32'h40C00000, 32'h3E800000, 32'h40200000, 32'h40000000};
    exp_d = '{32'h40400000, 32'h40800000, 32'h3F400000, 32'h41800000};
`ifdef FP_ARB_ROUND_ROBIN_EN
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    g_log.delete(); d_log.delete();
    rsp_ready = 4'b1111; req = 4'b1111;
    cyc = 0;
    while (g_log.size() < 5 && cyc < 200) begin @(negedge clk); cyc++; end
    req = '0;
    cyc = 0;
    while ((busy || d_log.size() < 5) && cyc < 60) begin @(negedge clk); cyc++; end
    rsp_ready = '0;
    check("cont_grants", 32'(g_log.size()), 32'd5);
    check("cont_results", 32'(d_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (g_log.size() > k) check($sformatf("cont_gnt%0d", k), 32'(g_log[k]), 32'(exp_g[k]));
      if (d_log.size() > k) check($sformatf("cont_data%0d", k), d_log[k], exp_d[exp_g[k]]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
